sevenseg_mux_decoder: RTL and testbench
=======================================

Name: sevenseg_mux_decoder

Overview:
- Receive-side decoder for the game's two-digit multiplexed seven-segment output (seg[6:0], dig1, dig2, seginv polarity).
- Samples the scanned display and rebuilds the two displayed hex digits, with blank and invalid-pattern flags and a change strobe.
- Used as a self-check monitor in the test harness and as a score reader for a future auto-player.

Parameters:
- STABLE_CYCLES, 16, consecutive identical active samples required before a digit is committed (range 1..255).
- CNT_W, 8, width of the stability counter; must hold STABLE_CYCLES.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- seg  input  7  segment lines, seg[0]=a … seg[6]=g
- dig1  input  1  high-digit select
- dig2  input  1  low-digit select
- inv  input  1  polarity: 0 = segs/digs active-high; 1 = segs and digs all active-low
- hi  output  4  committed high digit value
- lo  output  4  committed low digit value
- hi_blank  output  1  high digit committed as blank
- lo_blank  output  1  low digit committed as blank
- hi_err  output  1  high digit committed pattern not in table
- lo_err  output  1  low digit committed pattern not in table
- valid  output  1  both digits committed at least once since reset
- changed  output  1  one-cycle pulse when any committed output changes
- collision  output  1  one-cycle pulse when both digit selects are active in the same sample

Behaviour:
- Reset: all outputs 0; counters, candidates and the "committed-once" flags cleared.
- Input stage: seg, dig1, dig2 and inv are registered once. Effective values are XORed with inv: s = seg^{7{inv}}, d1 = dig1^inv, d2 = dig2^inv.
- Sample classification per cycle:
  - exactly one of d1/d2 active: active sample for that digit.
  - both active: collision pulse next cycle; sample discarded; both counters cleared.
  - neither active: counters and candidates hold.
- Per-digit tracker (hi uses d1, lo uses d2):
  - Active sample with s == candidate: counter increments, saturating at STABLE_CYCLES.
  - Active sample with s != candidate: candidate = s, counter = 1.
  - Counter reaching STABLE_CYCLES (transition edge only) commits the candidate once.
  - Further samples of the same run do not re-commit.
  - Selecting the other digit clears this digit's counter, but not its candidate.
- Decode at commit:
  - 3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7D=6, 07=7, 7F=8, 6F=9, 77=A, 7C=b, 39=C, 5E=d, 79=E, 71=F.
  - 00: blank=1, value 0, err=0.
  - Any other pattern: err=1, value 0, blank=0.
- Latency: if seg/dig are held from edge t, the commit is visible at edge t+STABLE_CYCLES+1.
- changed pulses in the commit cycle only if {value, blank, err} of that digit differ from the previous committed state.
- The first commit of each digit after reset always pulses changed.
- valid rises on the cycle the second of the two digits first commits; it stays high until rst.
- Simultaneous commits of hi and lo in one cycle: both outputs update; a single changed pulse.
- inv toggling mid-run: effective patterns change, so candidates restart naturally; no special handling.
- rst mid-run: all state is cleared on that edge; outputs read 0 the cycle after.

Test Plan:
- Hold inv=0, dig1=1, dig2=0, seg=0x5B for 20 cycles → hi=2 at cycle STABLE_CYCLES+1, changed pulse once, valid=0.
- Alternate dig1/seg=0x06 and dig2/seg=0x7D every 32 cycles → hi=1, lo=6, valid=1, exactly two changed pulses, then none while the pattern repeats.
- Repeat the previous scenario with inv=1 and all seg/dig inverted → identical hi/lo/valid results.
- dig1 active, seg=0x5B held for only 15 cycles, then seg=0x4F for 16 cycles → no commit of 2; hi=3 committed.
- seg=0x00 on dig2, then seg=0x12 on dig2 → lo_blank=1 first, then lo_err=1, lo_blank=0, changed pulsed both times.
- dig1=dig2=1 for 3 cycles mid-run → three collision pulses, counters restart, no commit; assert rst mid-count → all outputs 0 next cycle.

Source files
------------

// File: rtl/sevenseg_mux_decoder.sv
// Receive-side decoder for a two-digit multiplexed seven-segment display.
// Rebuilds the committed high/low hex digits with blank/error flags and change/collision strobes.
module sevenseg_mux_decoder #(
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg,
    input  logic       dig1,
    input  logic       dig2,
    input  logic       inv,
    output logic [3:0] hi,
    output logic [3:0] lo,
    output logic       hi_blank,
    output logic       lo_blank,
    output logic       hi_err,
    output logic       lo_err,
    output logic       valid,
    output logic       changed,
    output logic       collision
);

    localparam logic [CNT_W-1:0] STABLE    = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] STABLE_M1 = CNT_W'(STABLE_CYCLES - 1);

    // Returns {value[3:0], blank, err}.
    function automatic logic [5:0] decode(input logic [6:0] p);
        logic [5:0] r;
        r = {4'h0, 2'b01};
        case (p)
            7'h3F: r = {4'h0, 2'b00};
            7'h06: r = {4'h1, 2'b00};
            7'h5B: r = {4'h2, 2'b00};
            7'h4F: r = {4'h3, 2'b00};
            7'h66: r = {4'h4, 2'b00};
            7'h6D: r = {4'h5, 2'b00};
            7'h7D: r = {4'h6, 2'b00};
            7'h07: r = {4'h7, 2'b00};
            7'h7F: r = {4'h8, 2'b00};
            7'h6F: r = {4'h9, 2'b00};
            7'h77: r = {4'hA, 2'b00};
            7'h7C: r = {4'hB, 2'b00};
            7'h39: r = {4'hC, 2'b00};
            7'h5E: r = {4'hD, 2'b00};
            7'h79: r = {4'hE, 2'b00};
            7'h71: r = {4'hF, 2'b00};
            7'h00: r = {4'h0, 2'b10};
            default: r = {4'h0, 2'b01};
        endcase
        return r;
    endfunction

    logic [6:0]            seg_q, seg_d;
    logic                  dig1_q, dig1_d, dig2_q, dig2_d, inv_q, inv_d;
    logic [1:0][6:0]       cand_q, cand_d;
    logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]            commit_q, commit_d;
    logic [1:0][5:0]       disp_q, disp_d;
    logic [1:0]            once_q, once_d;
    logic                  valid_q, valid_d, changed_q, changed_d, collision_q, collision_d;

    logic [6:0] s_eff;
    logic       d1_eff, d2_eff, coll;
    logic [1:0] act, act_other;

    assign s_eff     = seg_q ^ {7{inv_q}};
    assign d1_eff    = dig1_q ^ inv_q;
    assign d2_eff    = dig2_q ^ inv_q;
    assign coll      = d1_eff & d2_eff;
    assign act       = {d2_eff & ~d1_eff, d1_eff & ~d2_eff};
    assign act_other = {act[0], act[1]};

    always_comb begin
        seg_d       = seg;
        dig1_d      = dig1;
        dig2_d      = dig2;
        inv_d       = inv;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        commit_d    = '0;
        disp_d      = disp_q;
        once_d      = once_q;
        changed_d   = 1'b0;
        collision_d = coll;
        for (int i = 0; i < 2; i++) begin
            if (coll) begin
                cnt_d[i] = '0;
            end else if (act[i]) begin
                if (s_eff == cand_q[i]) begin
                    if (cnt_q[i] != STABLE) begin
                        cnt_d[i]    = cnt_q[i] + 1'b1;
                        commit_d[i] = (cnt_q[i] == STABLE_M1);
                    end
                end else begin
                    cand_d[i]   = s_eff;
                    cnt_d[i]    = CNT_W'(1);
                    // A fresh run is already complete when one sample suffices.
                    commit_d[i] = (STABLE_CYCLES == 1);
                end
            end else if (act_other[i]) begin
                cnt_d[i] = '0;
            end
            if (commit_q[i]) begin
                disp_d[i] = decode(cand_q[i]);
                once_d[i] = 1'b1;
                if (!once_q[i] || (decode(cand_q[i]) != disp_q[i])) begin
                    changed_d = 1'b1;
                end
            end
        end
        valid_d = valid_q | (&once_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q       <= '0;
            dig1_q      <= 1'b0;
            dig2_q      <= 1'b0;
            inv_q       <= 1'b0;
            cand_q      <= '0;
            cnt_q       <= '0;
            commit_q    <= '0;
            disp_q      <= '0;
            once_q      <= '0;
            valid_q     <= 1'b0;
            changed_q   <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            seg_q       <= seg_d;
            dig1_q      <= dig1_d;
            dig2_q      <= dig2_d;
            inv_q       <= inv_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            commit_q    <= commit_d;
            disp_q      <= disp_d;
            once_q      <= once_d;
            valid_q     <= valid_d;
            changed_q   <= changed_d;
            collision_q <= collision_d;
        end
    end

    assign hi        = disp_q[0][5:2];
    assign hi_blank  = disp_q[0][1];
    assign hi_err    = disp_q[0][0];
    assign lo        = disp_q[1][5:2];
    assign lo_blank  = disp_q[1][1];
    assign lo_err    = disp_q[1][0];
    assign valid     = valid_q;
    assign changed   = changed_q;
    assign collision = collision_q;

endmodule

// File: tb/tb_sevenseg_mux_decoder.sv
// Directed bench for sevenseg_mux_decoder with STABLE_CYCLES = 16.
// Expected values are hand-derived from the input-register + 16-sample + commit-register timing.
module tb_sevenseg_mux_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] seg;
    logic       dig1, dig2, inv;
    logic [3:0] hi, lo;
    logic       hi_blank, lo_blank, hi_err, lo_err, valid, changed, collision;

    int n_checks = 0;
    int n_err    = 0;
    int chg      = 0;
    int col      = 0;

    sevenseg_mux_decoder #(.STABLE_CYCLES(16), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .seg(seg), .dig1(dig1), .dig2(dig2), .inv(inv),
        .hi(hi), .lo(lo), .hi_blank(hi_blank), .lo_blank(lo_blank),
        .hi_err(hi_err), .lo_err(lo_err), .valid(valid),
        .changed(changed), .collision(collision)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (changed)   chg++;
            if (collision) col++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; seg = '0; dig1 = 1'b0; dig2 = 1'b0; inv = 1'b0;
        run(2);
        rst = 1'b0;
        chg = 0;
        col = 0;
    endtask

    // Drives logical (active-high) values, applying the requested polarity on the pins.
    task automatic phase(input logic d1, input logic d2, input logic [6:0] sg,
                         input logic iv, input int n);
        inv  = iv;
        seg  = sg ^ {7{iv}};
        dig1 = d1 ^ iv;
        dig2 = d2 ^ iv;
        run(n);
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_flags", {hi_blank, lo_blank, hi_err, lo_err}, 0);
        chk("rst_valid", valid, 0);
        chk("rst_strobes", {changed, collision}, 0);

        // Single digit, commit latency boundary
        seg = 7'h5B; dig1 = 1'b1;
        run(17);
        chk("lat_before_commit", hi, 0);
        run(1);
        chk("lat_commit_hi", hi, 2);
        chk("lat_commit_changed", changed, 1);
        run(2);
        chk("lat_changed_count", chg, 1);
        chk("lat_valid_low", valid, 0);

        // Alternating digits, both polarities
        for (int iv = 0; iv < 2; iv++) begin
            do_reset();
            phase(1'b1, 1'b0, 7'h06, iv[0], 32);
            chk("alt_valid_after_hi", valid, 0);
            phase(1'b0, 1'b1, 7'h7D, iv[0], 32);
            chk("alt_hi", hi, 1);
            chk("alt_lo", lo, 6);
            chk("alt_valid", valid, 1);
            chk("alt_chg_first", chg, 2);
            chg = 0;
            for (int k = 0; k < 2; k++) begin
                phase(1'b1, 1'b0, 7'h06, iv[0], 32);
                phase(1'b0, 1'b1, 7'h7D, iv[0], 32);
            end
            chk("alt_chg_repeat", chg, 0);
            chk("alt_hilo_repeat", {hi, lo}, 8'h16);
            chk("alt_valid_hold", valid, 1);
        end

        // One sample short of stable, then a full run of another pattern
        do_reset();
        phase(1'b1, 1'b0, 7'h5B, 1'b0, 15);
        phase(1'b1, 1'b0, 7'h4F, 1'b0, 16);
        chk("short_no_commit", hi, 0);
        chk("short_no_changed", chg, 0);
        phase(1'b0, 1'b0, 7'h00, 1'b0, 2);
        chk("short_hi3", hi, 3);
        chk("short_chg", chg, 1);
        chk("short_err", hi_err, 0);

        // Blank then invalid pattern on the low digit
        do_reset();
        phase(1'b0, 1'b1, 7'h00, 1'b0, 20);
        chk("blank_flags", {lo_blank, lo_err}, 2'b10);
        chk("blank_val", lo, 0);
        chk("blank_chg", chg, 1);
        chg = 0;
        phase(1'b0, 1'b1, 7'h12, 1'b0, 20);
        chk("err_flags", {lo_blank, lo_err}, 2'b01);
        chk("err_val", lo, 0);
        chk("err_chg", chg, 1);

        // Collision restarts counting; reset mid-count clears everything
        do_reset();
        phase(1'b1, 1'b0, 7'h6D, 1'b0, 10);
        chk("coll_none_yet", col, 0);
        phase(1'b1, 1'b1, 7'h6D, 1'b0, 3);
        phase(1'b1, 1'b0, 7'h6D, 1'b0, 10);
        chk("coll_count", col, 3);
        chk("coll_no_commit", hi, 0);
        chk("coll_no_changed", chg, 0);
        phase(1'b1, 1'b0, 7'h6D, 1'b0, 10);
        chk("coll_then_commit", hi, 5);
        chk("coll_commit_chg", chg, 1);
        phase(1'b0, 1'b1, 7'h7D, 1'b0, 5);
        rst = 1'b1;
        run(1);
        chk("midrst_hilo", {hi, lo}, 0);
        chk("midrst_flags", {hi_blank, lo_blank, hi_err, lo_err, valid, changed, collision}, 0);
        rst = 1'b0;
        phase(1'b0, 1'b0, 7'h00, 1'b0, 3);
        chk("postrst_hold", {hi, lo, valid}, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
